id_branch_unit: RTL and testbench

Decode-stage branch resolution and hazard stall controller. Consumes the ID-stage forwarding selects, picks the branch/JALR operands from the register file, MEM ALU result or WB write data, and evaluates conditional branches, JAL and JALR in ID. Issues a PC redirect and an IF/ID flush, and stalls the front end when a branch operand cannot be forwarded yet: a producer is still in EX, or a load is in EX or MEM. Keeps saturating branch statistics counters.

---
 rtl/rv_pkg.sv | 57 +++++
 rtl/id_branch_compare.sv | 28 ++
 rtl/id_branch_unit.sv | 175 +++++++++++++++++
 tb/tb_id_branch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 decode constants, forwarding encodings and the branch-unit FSM
// state type, plus a helper that grades how far one source operand is from
// being forwardable.
package rv_pkg;

  // Opcodes of the control-transfer instructions resolved in ID.
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // Conditional branch funct3 codes (010 and 011 are unused and never taken).
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Operand select encodings coming from the ID-stage forwarding unit.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // IDLE evaluates hazards each cycle; HOLD is the second bubble of a
  // load-in-EX stall.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  // Number of stall cycles a single source register still needs before its
  // value can be forwarded into ID: 2 for a load in EX, 1 for an ALU result
  // in EX or a load in MEM, 0 otherwise. x0 never stalls.
  function automatic logic [1:0] src_need(
    input logic [4:0] rs,
    input logic       ex_reg_write,
    input logic       ex_mem_read,
    input logic [4:0] ex_rd,
    input logic       mem_mem_read,
    input logic [4:0] mem_rd
  );
    logic ex_hit;
    ex_hit = ex_reg_write && (ex_rd == rs);
    if (rs == 5'd0) begin
      return 2'd0;
    end else if (ex_hit && ex_mem_read) begin
      return 2'd2;
    end else if (ex_hit) begin
      return 2'd1;
    end else if (mem_mem_read && (mem_rd == rs)) begin
      return 2'd1;
    end else begin
      return 2'd0;
    end
  endfunction

endpackage

// File: rtl/id_branch_compare.sv
// Conditional-branch condition evaluator: decides taken/not-taken from the two
// resolved operands and funct3. Purely combinational.
module id_branch_compare
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [2:0]      funct3,
  output logic            taken
);

  // Select the comparison named by funct3; reserved codes fall through to 0.
  always_comb begin
    taken = 1'b0;
    case (funct3)
      F3_BEQ:  taken = (op_a == op_b);
      F3_BNE:  taken = (op_a != op_b);
      F3_BLT:  taken = ($signed(op_a) <  $signed(op_b));
      F3_BGE:  taken = ($signed(op_a) >= $signed(op_b));
      F3_BLTU: taken = (op_a <  op_b);
      F3_BGEU: taken = (op_a >= op_b);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/id_branch_unit.sv
// Decode-stage branch resolution and hazard stall controller. Picks branch and
// JALR operands from RF / WB / MEM, resolves BRANCH, JAL and JALR in ID,
// issues redirect + IF/ID flush, stalls the front end while an operand is not
// yet forwardable, and keeps saturating branch statistics.
module id_branch_unit
  import rv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ID_valid,
  input  logic [6:0]       ID_opcode,
  input  logic [2:0]       ID_funct3,
  input  logic [XLEN-1:0]  ID_pc,
  input  logic [XLEN-1:0]  ID_imm,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [XLEN-1:0]  RF_ReadData1,
  input  logic [XLEN-1:0]  RF_ReadData2,
  input  logic [1:0]       ForwardA,
  input  logic [1:0]       ForwardB,
  input  logic [XLEN-1:0]  MEM_ALUResult,
  input  logic [XLEN-1:0]  WB_WriteData,
  input  logic             EX_cntl_RegWrite,
  input  logic             EX_cntl_MemRead,
  input  logic [4:0]       EX_WriteRegNum,
  input  logic             MEM_cntl_MemRead,
  input  logic [4:0]       MEM_WriteRegNum,
  output logic             Stall,
  output logic             Redirect,
  output logic [XLEN-1:0]  RedirectTarget,
  output logic             Flush_IFID,
  output logic [CNT_W-1:0] BranchCount,
  output logic [CNT_W-1:0] TakenCount
);

  state_t            state;
  state_t            next_state;

  logic              is_branch;
  logic              is_jalr;
  logic              is_jal;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic [1:0]        need_a;
  logic [1:0]        need_b;
  logic [1:0]        need;
  logic              stall_raw;
  logic              active;
  logic              cond_taken;
  logic              redirect_raw;
  logic [XLEN-1:0]   jalr_sum;
  logic [XLEN-1:0]   target;
  logic              branch_resolves;

  // Instruction class; a bubble in IF/ID decodes as nothing.
  assign is_branch = ID_valid && (ID_opcode == OP_BRANCH);
  assign is_jalr   = ID_valid && (ID_opcode == OP_JALR);
  assign is_jal    = ID_valid && (ID_opcode == OP_JAL);

  // Operand A mux; the unused select code 11 reads the register file.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // that no path leaves it unassigned and infers a latch.
    op_a = RF_ReadData1;
    case (ForwardA)
      FWD_RF:  op_a = RF_ReadData1;
      FWD_WB:  op_a = WB_WriteData;
      FWD_MEM: op_a = MEM_ALUResult;
      default: op_a = RF_ReadData1;
    endcase
  end

  // Operand B mux, same encoding as operand A.
  always_comb begin
    op_b = RF_ReadData2;
    case (ForwardB)
      FWD_RF:  op_b = RF_ReadData2;
      FWD_WB:  op_b = WB_WriteData;
      FWD_MEM: op_b = MEM_ALUResult;
      default: op_b = RF_ReadData2;
    endcase
  end

  // Worst-case stall demand over the sources this instruction actually reads:
  // BRANCH reads rs1 and rs2, JALR reads rs1 only, JAL reads nothing.
  assign need_a = (is_branch || is_jalr)
                ? src_need(ID_rs1, EX_cntl_RegWrite, EX_cntl_MemRead,
                           EX_WriteRegNum, MEM_cntl_MemRead, MEM_WriteRegNum)
                : 2'd0;
  assign need_b = is_branch
                ? src_need(ID_rs2, EX_cntl_RegWrite, EX_cntl_MemRead,
                           EX_WriteRegNum, MEM_cntl_MemRead, MEM_WriteRegNum)
                : 2'd0;
  assign need   = (need_a > need_b) ? need_a : need_b;

  // FSM state register; reset abandons any pending HOLD.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and raw stall: IDLE stalls on any hazard and moves to HOLD for
  // a load in EX; HOLD stalls unconditionally and masks everything else.
  always_comb begin
    next_state = state;
    stall_raw  = 1'b0;
    case (state)
      IDLE: begin
        stall_raw = (need != 2'd0);
        if (need == 2'd2) begin
          next_state = HOLD;
        end
      end
      HOLD: begin
        stall_raw  = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // The instruction in ID resolves only when it is not being held back and
  // the unit is out of reset.
  assign active = reset_n && !stall_raw;

  id_branch_compare #(
    .XLEN (XLEN)
  ) u_compare (
    .op_a   (op_a),
    .op_b   (op_b),
    .funct3 (ID_funct3),
    .taken  (cond_taken)
  );

  // JALR target has bit 0 cleared; branch and JAL are PC-relative. All sums
  // wrap at XLEN bits.
  assign jalr_sum = op_a + ID_imm;
  assign target   = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ID_pc + ID_imm);

  assign redirect_raw = active && ((is_branch && cond_taken) || is_jal || is_jalr);

  assign Stall          = reset_n && stall_raw;
  assign Redirect       = redirect_raw;
  assign Flush_IFID     = redirect_raw;
  assign RedirectTarget = redirect_raw ? target : '0;

  assign branch_resolves = active && is_branch;

  // Saturating statistics: every resolved conditional branch, and the taken
  // subset; both stick at all-ones.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      BranchCount <= '0;
      TakenCount  <= '0;
    end else if (branch_resolves) begin
      if (BranchCount != {CNT_W{1'b1}}) begin
        BranchCount <= BranchCount + CNT_W'(1);
      end
      if (cond_taken && (TakenCount != {CNT_W{1'b1}})) begin
        TakenCount <= TakenCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_id_branch_unit.sv
// Self-checking bench for id_branch_unit: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the branch unit.
module tb_id_branch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ID_valid;
  logic [6:0]  ID_opcode;
  logic [2:0]  ID_funct3;
  logic [31:0] ID_pc, ID_imm;
  logic [4:0]  ID_rs1, ID_rs2;
  logic [31:0] RF_ReadData1, RF_ReadData2;
  logic [1:0]  ForwardA, ForwardB;
  logic [31:0] MEM_ALUResult, WB_WriteData;
  logic        EX_cntl_RegWrite, EX_cntl_MemRead;
  logic [4:0]  EX_WriteRegNum;
  logic        MEM_cntl_MemRead;
  logic [4:0]  MEM_WriteRegNum;
  logic        Stall, Redirect, Flush_IFID;
  logic [31:0] RedirectTarget;
  logic [15:0] BranchCount, TakenCount;

  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] JALR = 7'b1100111;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] ALU  = 7'b0110011;

  id_branch_unit #(.XLEN(32), .CNT_W(16)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .ID_valid         (ID_valid),
    .ID_opcode        (ID_opcode),
    .ID_funct3        (ID_funct3),
    .ID_pc            (ID_pc),
    .ID_imm           (ID_imm),
    .ID_rs1           (ID_rs1),
    .ID_rs2           (ID_rs2),
    .RF_ReadData1     (RF_ReadData1),
    .RF_ReadData2     (RF_ReadData2),
    .ForwardA         (ForwardA),
    .ForwardB         (ForwardB),
    .MEM_ALUResult    (MEM_ALUResult),
    .WB_WriteData     (WB_WriteData),
    .EX_cntl_RegWrite (EX_cntl_RegWrite),
    .EX_cntl_MemRead  (EX_cntl_MemRead),
    .EX_WriteRegNum   (EX_WriteRegNum),
    .MEM_cntl_MemRead (MEM_cntl_MemRead),
    .MEM_WriteRegNum  (MEM_WriteRegNum),
    .Stall            (Stall),
    .Redirect         (Redirect),
    .RedirectTarget   (RedirectTarget),
    .Flush_IFID       (Flush_IFID),
    .BranchCount      (BranchCount),
    .TakenCount       (TakenCount)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference state: a pending second stall cycle and the two counters.
  bit model_hold = 1'b0;
  int model_bc   = 0;
  int model_tc   = 0;

  // Expected values for the cycle currently in ID.
  bit          exp_stall, exp_redir, exp_resolve, exp_taken, exp_hold_next;
  logic [31:0] exp_target;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Stall cycles one source register still needs, read straight from the
  // hazard rules.
  function automatic int need_of(input logic [4:0] rs);
    if (rs == 5'd0) return 0;
    if (EX_cntl_RegWrite && EX_WriteRegNum == rs && EX_cntl_MemRead) return 2;
    if (EX_cntl_RegWrite && EX_WriteRegNum == rs) return 1;
    if (MEM_cntl_MemRead && MEM_WriteRegNum == rs) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
    if (sel == 2'b01) return WB_WriteData;
    if (sel == 2'b10) return MEM_ALUResult;
    return rf;
  endfunction

  // Whole-cycle behaviour of the unit for the current inputs.
  task automatic model_eval();
    bit is_br, is_jr, is_j;
    int need, nb;
    logic [31:0] a, b;
    is_br = ID_valid && ID_opcode == BR;
    is_jr = ID_valid && ID_opcode == JALR;
    is_j  = ID_valid && ID_opcode == JAL;
    need = 0;
    if (is_br || is_jr) need = need_of(ID_rs1);
    if (is_br) begin
      nb = need_of(ID_rs2);
      if (nb > need) need = nb;
    end
    exp_stall     = model_hold ? 1'b1 : (need > 0);
    exp_hold_next = !model_hold && need == 2;
    a = pick(ForwardA, RF_ReadData1);
    b = pick(ForwardB, RF_ReadData2);
    case (ID_funct3)
      3'd0: exp_taken = (a == b);
      3'd1: exp_taken = (a != b);
      3'd4: exp_taken = ($signed(a) <  $signed(b));
      3'd5: exp_taken = ($signed(a) >= $signed(b));
      3'd6: exp_taken = (a <  b);
      3'd7: exp_taken = (a >= b);
      default: exp_taken = 1'b0;
    endcase
    exp_resolve = is_br && !exp_stall;
    exp_redir   = !exp_stall && ((is_br && exp_taken) || is_j || is_jr);
    if (!exp_redir)  exp_target = 32'd0;
    else if (is_jr)  exp_target = (a + ID_imm) & ~32'd1;
    else             exp_target = ID_pc + ID_imm;
  endtask

  // Entered at posedge+1 with inputs driven: check the combinational outputs.
  task automatic eval_check(input string tag);
    #3;
    model_eval();
    check({tag, ".stall"},  {31'd0, Stall},      {31'd0, exp_stall});
    check({tag, ".redir"},  {31'd0, Redirect},   {31'd0, exp_redir});
    check({tag, ".flush"},  {31'd0, Flush_IFID}, {31'd0, exp_redir});
    check({tag, ".target"}, RedirectTarget,      exp_target);
  endtask

  // Clock the cycle through, update the model and check the counters.
  task automatic advance(input string tag);
    if (exp_resolve) begin
      if (model_bc < 65535) model_bc++;
      if (exp_taken && model_tc < 65535) model_tc++;
    end
    model_hold = exp_hold_next;
    @(posedge clk);
    #1;
    check({tag, ".bcnt"}, {16'd0, BranchCount}, model_bc);
    check({tag, ".tcnt"}, {16'd0, TakenCount},  model_tc);
  endtask

  task automatic cycle(input string tag);
    eval_check(tag);
    advance(tag);
  endtask

  task automatic clear_inputs();
    ID_valid = 0; ID_opcode = ALU; ID_funct3 = 0; ID_pc = 0; ID_imm = 0;
    ID_rs1 = 0; ID_rs2 = 0; RF_ReadData1 = 0; RF_ReadData2 = 0;
    ForwardA = 0; ForwardB = 0; MEM_ALUResult = 0; WB_WriteData = 0;
    EX_cntl_RegWrite = 0; EX_cntl_MemRead = 0; EX_WriteRegNum = 0;
    MEM_cntl_MemRead = 0; MEM_WriteRegNum = 0;
  endtask

  task automatic set_branch(input logic [2:0] f3, input logic [4:0] r1, input logic [4:0] r2);
    clear_inputs();
    ID_valid = 1; ID_opcode = BR; ID_funct3 = f3; ID_rs1 = r1; ID_rs2 = r2;
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0] ops [4];
    ops[0] = BR; ops[1] = JALR; ops[2] = JAL; ops[3] = ALU;

    // Reset held: outputs quiet even with a taken branch presented.
    reset_n = 0;
    set_branch(3'd0, 5'd1, 5'd2);
    RF_ReadData1 = 5; RF_ReadData2 = 5; ID_pc = 32'h100; ID_imm = 32'h20;
    #3;
    check("rst.stall", {31'd0, Stall}, 0);
    check("rst.redir", {31'd0, Redirect}, 0);
    check("rst.flush", {31'd0, Flush_IFID}, 0);
    check("rst.target", RedirectTarget, 0);
    check("rst.bcnt", {16'd0, BranchCount}, 0);
    check("rst.tcnt", {16'd0, TakenCount}, 0);
    @(posedge clk);
    #1;
    reset_n = 1;

    // BEQ from the register file, taken.
    eval_check("beq");
    check("beq.tgt_const", RedirectTarget, 32'h120);
    check("beq.redir_const", {31'd0, Redirect}, 1);
    advance("beq");
    check("beq.bc_const", {16'd0, BranchCount}, 1);
    check("beq.tc_const", {16'd0, TakenCount}, 1);

    // ALU producer of x3 in EX: one stall cycle, then forwarded from MEM.
    set_branch(3'd1, 5'd3, 5'd0);
    EX_cntl_RegWrite = 1; EX_WriteRegNum = 3;
    eval_check("bne_ex");
    check("bne_ex.stall_const", {31'd0, Stall}, 1);
    advance("bne_ex");
    set_branch(3'd1, 5'd3, 5'd0);
    ForwardA = 2'b10; MEM_ALUResult = 7;
    eval_check("bne_fwd");
    check("bne_fwd.redir_const", {31'd0, Redirect}, 1);
    advance("bne_fwd");

    // Load of x4 in EX: two stall cycles, then BLT forwarded from WB.
    set_branch(3'd4, 5'd4, 5'd5);
    EX_cntl_RegWrite = 1; EX_cntl_MemRead = 1; EX_WriteRegNum = 4;
    eval_check("blt_ld1");
    check("blt_ld1.stall_const", {31'd0, Stall}, 1);
    advance("blt_ld1");
    set_branch(3'd4, 5'd4, 5'd5);
    MEM_cntl_MemRead = 1; MEM_WriteRegNum = 4;
    eval_check("blt_ld2");
    check("blt_ld2.stall_const", {31'd0, Stall}, 1);
    advance("blt_ld2");
    set_branch(3'd4, 5'd4, 5'd5);
    ForwardA = 2'b01; WB_WriteData = 32'hFFFF_FFFF; RF_ReadData2 = 0;
    eval_check("blt_ld3");
    check("blt_ld3.stall_const", {31'd0, Stall}, 0);
    check("blt_ld3.redir_const", {31'd0, Redirect}, 1);
    advance("blt_ld3");

    // JALR: bit 0 of the target cleared, counters untouched.
    clear_inputs();
    ID_valid = 1; ID_opcode = JALR; ID_rs1 = 1; ID_imm = 3; RF_ReadData1 = 32'h1000;
    ID_pc = 32'h400;
    eval_check("jalr");
    check("jalr.tgt_const", RedirectTarget, 32'h1002);
    advance("jalr");
    // JALR through x0 with a load targeting x0 in EX: no stall.
    clear_inputs();
    ID_valid = 1; ID_opcode = JALR; ID_rs1 = 0; ID_imm = 32'h81;
    EX_cntl_RegWrite = 1; EX_cntl_MemRead = 1; EX_WriteRegNum = 0;
    eval_check("jalr_x0");
    check("jalr_x0.stall_const", {31'd0, Stall}, 0);
    advance("jalr_x0");

    // Unsigned vs signed compare on the same operands.
    set_branch(3'd6, 5'd6, 5'd7);
    RF_ReadData1 = 32'hFFFF_FFFF; RF_ReadData2 = 1; ID_pc = 32'h200; ID_imm = 32'hFFFF_FFF0;
    eval_check("bltu");
    check("bltu.redir_const", {31'd0, Redirect}, 0);
    advance("bltu");
    ID_funct3 = 3'd4;
    eval_check("blt");
    check("blt.tgt_const", RedirectTarget, 32'h1F0);
    advance("blt");

    // Saturation: enough taken branches to pin both counters.
    set_branch(3'd0, 5'd1, 5'd2);
    RF_ReadData1 = 9; RF_ReadData2 = 9;
    for (int i = 0; i < 32'h10000; i++) cycle("sat");
    check("sat.bc_const", {16'd0, BranchCount}, 32'hFFFF);
    check("sat.tc_const", {16'd0, TakenCount}, 32'hFFFF);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      clear_inputs();
      ID_valid         = ($urandom_range(0, 7) != 0);
      ID_opcode        = ops[$urandom_range(0, 3)];
      ID_funct3        = 3'($urandom_range(0, 7));
      ID_pc            = $urandom;
      ID_imm           = rand_data();
      ID_rs1           = 5'($urandom_range(0, 5));
      ID_rs2           = 5'($urandom_range(0, 5));
      RF_ReadData1     = rand_data();
      RF_ReadData2     = rand_data();
      ForwardA         = 2'($urandom_range(0, 3));
      ForwardB         = 2'($urandom_range(0, 3));
      MEM_ALUResult    = rand_data();
      WB_WriteData     = rand_data();
      EX_cntl_RegWrite = ($urandom_range(0, 2) == 0);
      EX_cntl_MemRead  = ($urandom_range(0, 1) == 0);
      EX_WriteRegNum   = 5'($urandom_range(0, 5));
      MEM_cntl_MemRead = ($urandom_range(0, 3) == 0);
      MEM_WriteRegNum  = 5'($urandom_range(0, 5));
      cycle("rand");
    end
    clear_inputs();
    cycle("drain");

    // Reset asserted while in HOLD drops the stall at once.
    set_branch(3'd0, 5'd4, 5'd0);
    EX_cntl_RegWrite = 1; EX_cntl_MemRead = 1; EX_WriteRegNum = 4;
    cycle("hold_enter");
    clear_inputs();
    #2;
    check("hold.stall_const", {31'd0, Stall}, 1);
    reset_n = 0;
    #1;
    check("hold_rst.stall", {31'd0, Stall}, 0);
    check("hold_rst.redir", {31'd0, Redirect}, 0);
    check("hold_rst.bcnt", {16'd0, BranchCount}, 0);
    check("hold_rst.tcnt", {16'd0, TakenCount}, 0);
    model_hold = 0; model_bc = 0; model_tc = 0;
    @(posedge clk);
    #1;
    reset_n = 1;
    set_branch(3'd0, 5'd4, 5'd0);
    cycle("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
